// File: rtl/dvp_tx_generator.sv
// DVP camera-side transmitter: serialises RGB565 pixels onto an 8-bit DVP bus
// with PCLK = clk/2. All DVP outputs change only on the fall cycle (ph == 1).
module dvp_tx_generator #(
  parameter int DVP_DATA_W = 8,
  parameter int RGB_PXL_W  = 16,
  parameter int H_ACT      = 640,
  parameter int H_BLANK    = 144,
  parameter int H_SYNC     = 16,
  parameter int V_SYNC     = 3,
  parameter int V_BACK     = 17,
  parameter int V_ACT      = 480,
  parameter int V_FRONT    = 10,
  parameter int CNT_W      = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [RGB_PXL_W-1:0]  pxl_i,
  input  logic                  pxl_vld_i,
  output logic                  pxl_rdy_o,
  output logic [DVP_DATA_W-1:0] dvp_d_o,
  output logic                  dvp_href_o,
  output logic                  dvp_hsync_o,
  output logic                  dvp_vsync_o,
  output logic                  dvp_pclk_o,
  output logic                  frame_done_o,
  output logic                  underrun_o
);

  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(2*H_ACT + H_BLANK - 1);
  localparam logic [CNT_W-1:0] H_ACT_END   = CNT_W'(2*H_ACT);
  localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(2*H_ACT + H_SYNC);
  localparam logic [CNT_W-1:0] VSYNC_LAST  = CNT_W'(V_SYNC - 1);
  localparam logic [CNT_W-1:0] VBACK_LAST  = CNT_W'(V_BACK - 1);
  localparam logic [CNT_W-1:0] VACT_LAST   = CNT_W'(V_ACT - 1);
  localparam logic [CNT_W-1:0] VFRONT_LAST = CNT_W'(V_FRONT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]        v_cnt_q, v_cnt_d;
  logic                    ph_q, ph_d;
  logic [DVP_DATA_W-1:0]   d_q, d_d;
  logic [DVP_DATA_W-1:0]   lo_q, lo_d;
  logic                    href_q, href_d;
  logic                    hsync_q, hsync_d;
  logic                    vsync_q, vsync_d;
  logic                    underrun_q, underrun_d;

  logic [CNT_W-1:0]        v_last;
  logic                    line_end;
  logic                    frame_end;
  logic                    nxt_act_slot;
  logic                    load;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Next-state: counters describe the byte-slot currently on the bus
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    case (state_q)
      S_VSYNC:  v_last = VSYNC_LAST;
      S_VBACK:  v_last = VBACK_LAST;
      S_ACTIVE: v_last = VACT_LAST;
      S_VFRONT: v_last = VFRONT_LAST;
      default:  v_last = '0;
    endcase
    line_end  = (h_cnt_q == H_LAST);
    frame_end = (state_q == S_VFRONT) && line_end && (v_cnt_q == v_last);
    if (ph_q) begin
      if (state_q == S_IDLE) begin
        if (start_i) begin
          state_d = S_VSYNC;
          h_cnt_d = '0;
          v_cnt_d = '0;
        end
      end else if (!line_end) begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = '0;
        if (v_cnt_q != v_last) begin
          v_cnt_d = v_cnt_q + CNT_W'(1);
        end else begin
          v_cnt_d = '0;
          case (state_q)
            S_VSYNC:  state_d = S_VBACK;
            S_VBACK:  state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_VFRONT;
            S_VFRONT: state_d = start_i ? S_VSYNC : S_IDLE;
            default:  state_d = S_IDLE;
          endcase
        end
      end
    end
  end

  // Outputs for the upcoming slot are derived from the next-state values
  always_comb begin
    ph_d       = ~ph_q;
    d_d        = d_q;
    lo_d       = lo_q;
    href_d     = href_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    nxt_act_slot = (state_d == S_ACTIVE) && (h_cnt_d < H_ACT_END);
    load       = ph_q && nxt_act_slot && !h_cnt_d[0];
    underrun_d = load && !pxl_vld_i;
    if (ph_q) begin
      href_d  = nxt_act_slot;
      vsync_d = (state_d == S_VSYNC);
      hsync_d = (state_d != S_IDLE) && (h_cnt_d >= H_ACT_END) &&
                (h_cnt_d < H_SYNC_END);
      if (load) begin
        d_d  = pxl_vld_i ? pxl_i[RGB_PXL_W-1 -: DVP_DATA_W] : '0;
        lo_d = pxl_vld_i ? pxl_i[DVP_DATA_W-1:0] : '0;
      end else if (nxt_act_slot) begin
        d_d = lo_q;
      end else begin
        d_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q       <= 1'b0;
      d_q        <= '0;
      lo_q       <= '0;
      href_q     <= 1'b0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      ph_q       <= ph_d;
      d_q        <= d_d;
      lo_q       <= lo_d;
      href_q     <= href_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      underrun_q <= underrun_d;
    end
  end

  assign pxl_rdy_o    = load;
  assign frame_done_o = ph_q && frame_end;
  assign dvp_pclk_o   = ph_q;
  assign dvp_d_o      = d_q;
  assign dvp_href_o   = href_q;
  assign dvp_hsync_o  = hsync_q;
  assign dvp_vsync_o  = vsync_q;
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_dvp_tx_generator.sv
// Directed bench for dvp_tx_generator using the small test-plan geometry
// (line = 14 slots, frame = 5 lines = 140 clk).
module tb_dvp_tx_generator;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [15:0] pxl_i;
  logic        pxl_vld_i;
  logic        pxl_rdy_o;
  logic [7:0]  dvp_d_o;
  logic        dvp_href_o;
  logic        dvp_hsync_o;
  logic        dvp_vsync_o;
  logic        dvp_pclk_o;
  logic        frame_done_o;
  logic        underrun_o;

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] pix [8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                           16'h1357, 16'h2468, 16'hACE0, 16'hBDF1};

  dvp_tx_generator #(
    .DVP_DATA_W(8), .RGB_PXL_W(16), .H_ACT(4), .H_BLANK(6), .H_SYNC(2),
    .V_SYNC(1), .V_BACK(1), .V_ACT(2), .V_FRONT(1), .CNT_W(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .pxl_i(pxl_i),
    .pxl_vld_i(pxl_vld_i), .pxl_rdy_o(pxl_rdy_o), .dvp_d_o(dvp_d_o),
    .dvp_href_o(dvp_href_o), .dvp_hsync_o(dvp_hsync_o),
    .dvp_vsync_o(dvp_vsync_o), .dvp_pclk_o(dvp_pclk_o),
    .frame_done_o(frame_done_o), .underrun_o(underrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".d"},     16'(dvp_d_o), 16'h0);
    chk({tag, ".href"},  16'(dvp_href_o), 16'h0);
    chk({tag, ".hsync"}, 16'(dvp_hsync_o), 16'h0);
    chk({tag, ".vsync"}, 16'(dvp_vsync_o), 16'h0);
    chk({tag, ".rdy"},   16'(pxl_rdy_o), 16'h0);
    chk({tag, ".done"},  16'(frame_done_o), 16'h0);
    chk({tag, ".und"},   16'(underrun_o), 16'h0);
  endtask

  task automatic idle_chk(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk_quiet(tag);
      tick();
    end
  endtask

  // Wait (bounded) for a fall cycle so a start takes effect on the next edge.
  task automatic align();
    for (int i = 0; i < 4; i++) begin
      if (dvp_pclk_o === 1'b1) break;
      tick();
    end
    chk("align.pclk", 16'(dvp_pclk_o), 16'h1);
  endtask

  // Check clk k = 1..kmax of a frame; k = 1 is the first clk of VSYNC slot 0.
  task automatic run_frame(input bit drop, input int kmax);
    for (int k = 1; k <= kmax; k++) begin
      int s, ln, h, pi, ns, nl, nh, npi;
      bit act, e_rdy, e_und;
      logic [15:0] w;
      logic [7:0]  e_d;
      s  = (k - 1) / 2;
      ln = s / 14;
      h  = s % 14;
      act = (ln == 2 || ln == 3) && h < 8;
      pi  = (ln - 2) * 4 + h / 2;
      e_d = 8'h00;
      if (act && !(drop && pi == 2)) begin
        w   = pix[pi];
        e_d = (h % 2 == 0) ? w[15:8] : w[7:0];
      end
      ns = k / 2;
      nl = ns / 14;
      nh = ns % 14;
      e_rdy = (k % 2 == 0) && ns < 70 && (nl == 2 || nl == 3) && nh < 8 &&
              (nh % 2 == 0);
      e_und = drop && act && pi == 2 && (h % 2 == 0) && (k % 2 == 1);
      chk($sformatf("pclk@k%0d", k),  16'(dvp_pclk_o),  16'(k % 2 == 0));
      chk($sformatf("vsync@k%0d", k), 16'(dvp_vsync_o), 16'(ln == 0));
      chk($sformatf("hsync@k%0d", k), 16'(dvp_hsync_o), 16'(h == 8 || h == 9));
      chk($sformatf("href@k%0d", k),  16'(dvp_href_o),  16'(act));
      chk($sformatf("d@k%0d", k),     16'(dvp_d_o),     16'(e_d));
      chk($sformatf("rdy@k%0d", k),   16'(pxl_rdy_o),   16'(e_rdy));
      chk($sformatf("und@k%0d", k),   16'(underrun_o),  16'(e_und));
      chk($sformatf("done@k%0d", k),  16'(frame_done_o), 16'(k == 140));
      if (e_rdy) begin
        npi       = (nl - 2) * 4 + nh / 2;
        pxl_i     = pix[npi];
        pxl_vld_i = !(drop && npi == 2);
      end
      tick();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start_i   = 1'b0;
    pxl_i     = 16'h0;
    pxl_vld_i = 1'b1;

    // Reset state
    repeat (3) tick();
    chk_quiet("reset");
    chk("reset.pclk", 16'(dvp_pclk_o), 16'h0);

    // Idle after release: pclk toggles, everything else quiet
    rst_n = 1'b1;
    for (int j = 1; j <= 50; j++) begin
      tick();
      chk($sformatf("idle.pclk@%0d", j), 16'(dvp_pclk_o), 16'(j % 2));
      chk_quiet("idle");
    end

    // Single frame, source always valid, start pulsed one clk
    align();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    run_frame(1'b0, 140);
    idle_chk("post1", 6);

    // Underrun on the third pixel
    align();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    run_frame(1'b1, 140);
    pxl_vld_i = 1'b1;
    idle_chk("post2", 6);

    // Back-to-back frames, then release start during the second
    align();
    start_i = 1'b1;
    tick();
    run_frame(1'b0, 140);
    start_i = 1'b0;
    run_frame(1'b0, 140);
    idle_chk("post3", 6);

    // Reset during ACTIVE line 1 slot 3
    align();
    start_i = 1'b1;
    tick();
    run_frame(1'b0, 91);
    rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
    chk("midrst.pclk", 16'(dvp_pclk_o), 16'h0);
    tick();
    chk_quiet("midrst2");
    chk("midrst2.pclk", 16'(dvp_pclk_o), 16'h0);
    rst_n = 1'b1;
    align();
    tick();
    start_i = 1'b0;
    run_frame(1'b0, 140);
    idle_chk("post5", 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
